// File: rtl/calc_pkg.sv
// Shared types and defaults for the keypad calculator arithmetic engine.
package calc_pkg;

  localparam int MAX_DIGITS_DEF = 4;
  localparam int MAX_VAL_DEF    = 9999;
  localparam int MAG_W_DEF      = 14;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_CLR = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ENTER_A,
    OP_WAIT,
    ENTER_B,
    RESULT,
    ERROR
  } state_e;

endpackage

// File: rtl/calc_core_if.sv
// Key-event stream in, display value out. BCD signals exist only when
// CALC_BCD_OUT_EN is defined.
interface calc_core_if #(parameter int MAG_W = 14);
  logic             press;
  logic             is_num;
  logic             is_op;
  logic             is_eq;
  logic [3:0]       num_val;
  logic [1:0]       op_val;
  logic [MAG_W-1:0] disp_mag;
  logic             disp_neg;
  logic             err;
  logic             res_valid;
`ifdef CALC_BCD_OUT_EN
  logic [4*calc_pkg::MAX_DIGITS_DEF-1:0] disp_bcd;
  logic                                  bcd_valid;

  modport master (output press, is_num, is_op, is_eq, num_val, op_val,
                  input disp_mag, disp_neg, err, res_valid, disp_bcd, bcd_valid);
  modport slave  (input press, is_num, is_op, is_eq, num_val, op_val,
                  output disp_mag, disp_neg, err, res_valid, disp_bcd, bcd_valid);
`else
  modport master (output press, is_num, is_op, is_eq, num_val, op_val,
                  input disp_mag, disp_neg, err, res_valid);
  modport slave  (input press, is_num, is_op, is_eq, num_val, op_val,
                  output disp_mag, disp_neg, err, res_valid);
`endif
endinterface

// File: rtl/calc_bin2bcd.sv
// Iterative double-dabble converter; restarts whenever bin_i changes and
// presents the BCD result BIN_W cycles after the restart.
module calc_bin2bcd #(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [BIN_W-1:0]      bin_i,
  output logic [4*DIGITS-1:0]   bcd_o,
  output logic                  valid_o
);
  localparam int SH_W  = 4*DIGITS + BIN_W;
  localparam int CNT_W = $clog2(BIN_W + 1);

  logic [BIN_W-1:0]    last_q;
  logic [SH_W-1:0]     sh_q, sh_adj, sh_d;
  logic [CNT_W-1:0]    cnt_q;
  logic [4*DIGITS-1:0] bcd_q;
  logic                valid_q;

  always_comb begin
    sh_adj = sh_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (sh_adj[BIN_W+4*i +: 4] >= 4'd5)
        sh_adj[BIN_W+4*i +: 4] = sh_adj[BIN_W+4*i +: 4] + 4'd3;
    end
    sh_d = sh_adj << 1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_q  <= '0;
      sh_q    <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      valid_q <= 1'b0;
    end else if (bin_i != last_q) begin
      last_q  <= bin_i;
      sh_q    <= {{(4*DIGITS){1'b0}}, bin_i};
      cnt_q   <= CNT_W'(BIN_W);
      valid_q <= 1'b0;
    end else if (cnt_q != '0) begin
      sh_q  <= sh_d;
      cnt_q <= cnt_q - 1'b1;
      if (cnt_q == CNT_W'(1)) begin
        bcd_q   <= sh_d[SH_W-1 -: 4*DIGITS];
        valid_q <= 1'b1;
      end
    end
  end

  assign bcd_o   = bcd_q;
  assign valid_o = valid_q;
endmodule

// File: rtl/calc_core.sv
// Keypad calculator engine: operand entry, add/sub/mul, overflow trap.
// Optional BCD display output is enabled by defining CALC_BCD_OUT_EN.
module calc_core
  import calc_pkg::*;
#(
  parameter int MAX_DIGITS = MAX_DIGITS_DEF,
  parameter int MAX_VAL    = MAX_VAL_DEF,
  parameter int MAG_W      = MAG_W_DEF
) (
  input  logic      clk,
  input  logic      reset,
  calc_core_if.slave bus
);
  localparam int CNT_W = $clog2(MAX_DIGITS + 1);
  localparam int SUM_W = MAG_W + 2;
  localparam int PRD_W = 2 * MAG_W;

  typedef logic signed [MAG_W:0] opnd_t;

  state_e           state_q;
  op_e              op_q;
  opnd_t            a_q, b_q;
  logic [CNT_W-1:0] cnt_q;
  logic [MAG_W-1:0] disp_mag_q;
  logic             disp_neg_q, err_q, res_valid_q;

  logic              ev_eq, ev_op, ev_clr, ev_opr, ev_num, room;
  logic              a_neg, b_neg, r_neg, r_ovf;
  logic [MAG_W-1:0]  a_mag, b_mag, r_mag;
  logic signed [SUM_W-1:0] sum;
  logic [SUM_W-1:0]  sum_abs;
  logic [PRD_W-1:0]  r_wide;
  opnd_t             r_pos, r_val, a_app_d, b_app_d, digit_d;

  always_comb begin
    ev_eq  = bus.press & bus.is_eq;
    ev_op  = bus.press & ~bus.is_eq & bus.is_op;
    ev_clr = ev_op & (bus.op_val == OP_CLR);
    ev_opr = ev_op & (bus.op_val != OP_CLR);
    ev_num = bus.press & ~bus.is_eq & ~bus.is_op & bus.is_num & (bus.num_val <= 4'd9);
    room   = int'(cnt_q) < MAX_DIGITS;

    digit_d = opnd_t'(bus.num_val);
    a_app_d = a_q * opnd_t'(10) + digit_d;
    b_app_d = b_q * opnd_t'(10) + digit_d;

    a_neg = a_q[MAG_W];
    b_neg = b_q[MAG_W];
    a_mag = a_neg ? MAG_W'(-a_q) : MAG_W'(a_q);
    b_mag = b_neg ? MAG_W'(-b_q) : MAG_W'(b_q);

    sum     = (op_q == OP_SUB) ? SUM_W'(a_q) - SUM_W'(b_q) : SUM_W'(a_q) + SUM_W'(b_q);
    sum_abs = sum[SUM_W-1] ? unsigned'(-sum) : unsigned'(sum);

    if (op_q == OP_MUL) begin
      r_wide = PRD_W'(a_mag) * PRD_W'(b_mag);
      r_neg  = a_neg ^ b_neg;
    end else begin
      r_wide = PRD_W'(sum_abs);
      r_neg  = sum[SUM_W-1];
    end
    if (r_wide == '0) r_neg = 1'b0;
    r_ovf = r_wide > PRD_W'(MAX_VAL);
    r_mag = MAG_W'(r_wide);
    r_pos = opnd_t'({1'b0, r_mag});
    r_val = r_neg ? -r_pos : r_pos;
  end

  // Operand entry only ever builds non-negative values, so the raw low bits
  // of A/B are their magnitude while entering.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ENTER_A;
      op_q        <= OP_ADD;
      a_q         <= '0;
      b_q         <= '0;
      cnt_q       <= '0;
      disp_mag_q  <= '0;
      disp_neg_q  <= 1'b0;
      err_q       <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      res_valid_q <= 1'b0;
      if (ev_clr) begin
        state_q    <= ENTER_A;
        op_q       <= OP_ADD;
        a_q        <= '0;
        b_q        <= '0;
        cnt_q      <= '0;
        disp_mag_q <= '0;
        disp_neg_q <= 1'b0;
        err_q      <= 1'b0;
      end else if (state_q == ENTER_B && (ev_eq || ev_opr)) begin
        res_valid_q <= 1'b1;
        if (r_ovf) begin
          state_q    <= ERROR;
          err_q      <= 1'b1;
          disp_mag_q <= '0;
          disp_neg_q <= 1'b0;
        end else begin
          a_q        <= r_val;
          disp_mag_q <= r_mag;
          disp_neg_q <= r_neg;
          if (ev_eq) begin
            state_q <= RESULT;
          end else begin
            state_q <= OP_WAIT;
            op_q    <= op_e'(bus.op_val);
          end
        end
      end else begin
        case (state_q)
          ENTER_A: begin
            if (ev_eq) begin
              disp_mag_q  <= MAG_W'(a_q);
              disp_neg_q  <= 1'b0;
              res_valid_q <= 1'b1;
              state_q     <= RESULT;
            end else if (ev_opr) begin
              op_q    <= op_e'(bus.op_val);
              state_q <= OP_WAIT;
            end else if (ev_num && room) begin
              a_q        <= a_app_d;
              cnt_q      <= cnt_q + 1'b1;
              disp_mag_q <= MAG_W'(a_app_d);
              disp_neg_q <= 1'b0;
            end
          end
          OP_WAIT, RESULT: begin
            if (ev_opr) begin
              op_q    <= op_e'(bus.op_val);
              state_q <= OP_WAIT;
            end else if (ev_num && !ev_eq) begin
              if (state_q == OP_WAIT) begin
                b_q     <= digit_d;
                state_q <= ENTER_B;
              end else begin
                a_q     <= digit_d;
                state_q <= ENTER_A;
              end
              cnt_q      <= CNT_W'(1);
              disp_mag_q <= MAG_W'(bus.num_val);
              disp_neg_q <= 1'b0;
            end
          end
          ENTER_B: begin
            if (ev_num && room) begin
              b_q        <= b_app_d;
              cnt_q      <= cnt_q + 1'b1;
              disp_mag_q <= MAG_W'(b_app_d);
              disp_neg_q <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.disp_mag  = disp_mag_q;
  assign bus.disp_neg  = disp_neg_q;
  assign bus.err       = err_q;
  assign bus.res_valid = res_valid_q;

`ifdef CALC_BCD_OUT_EN
  calc_bin2bcd #(.BIN_W(MAG_W), .DIGITS(MAX_DIGITS)) u_bin2bcd (
    .clk     (clk),
    .reset   (reset),
    .bin_i   (disp_mag_q),
    .bcd_o   (bus.disp_bcd),
    .valid_o (bus.bcd_valid)
  );
`endif
endmodule

// File: doc/calc_core.md
Name: calc_core

Overview:
- Arithmetic engine of the keypad calculator.
- Consumes the decoded key-event stream from the keypad scanner: press, is_num, is_op, is_eq, num_val, op_val.
- Builds decimal operands, applies the selected operation, and drives a registered sign-magnitude value to the display path.
- Sits between the keypad interface and the 7-segment/display driver.

Parameters:
- MAX_DIGITS, 4, maximum decimal digits accepted per operand.
- MAX_VAL, 9999, largest representable magnitude; any result above it is an error.
- MAG_W, 14, magnitude width in bits; must hold MAX_VAL.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- press  in  1  one-cycle key-event strobe; qualifies the signals below.
- is_num  in  1  event is a digit.
- is_op  in  1  event is an operator.
- is_eq  in  1  event is "=".
- num_val  in  4  digit 0-9; values 10-15 are ignored.
- op_val  in  2  00 add, 01 sub, 10 mul, 11 clear.
- disp_mag  out  MAG_W  magnitude shown on the display.
- disp_neg  out  1  display value is negative.
- err  out  1  error state (overflow).
- res_valid  out  1  one-cycle pulse when a result is written to disp.

Behaviour:
- Reset: all outputs 0; A=0, B=0, op=add, digit count 0, state ENTER_A.
- Reset mid-operation discards everything.
- Events are sampled only on clk edges where press=1. With press=0, state holds.
- Priority when several flags are set: is_eq > is_op > is_num. A press with no flag set is ignored.
- Latency: outputs are registered and update on the same edge that samples press.
- Operands are stored signed, range -MAX_VAL..MAX_VAL. disp shows |value| and its sign.
- Digit entry: operand = operand*10 + num_val. Digits beyond MAX_DIGITS are ignored (no state change).
- op_val=11 (clear) from any state: A=B=0, disp=0, err=0, state ENTER_A.
- ENTER_A:
  - num: append digit to A; disp=A.
  - op: latch op; state OP_WAIT.
  - eq: disp=A, res_valid=1; state RESULT.
- OP_WAIT:
  - num: B=digit, count=1; disp=B; state ENTER_B.
  - op: replace latched op (no compute).
  - eq: ignored.
- ENTER_B:
  - num: append digit to B.
  - eq: R = A op B; disp=R, A=R, res_valid=1; state RESULT.
  - op: R = A op B; A=R; disp=R; res_valid=1; latch new op; state OP_WAIT (chaining).
- RESULT:
  - num: A=digit, count=1; state ENTER_A.
  - op: A kept; latch op; state OP_WAIT.
  - eq: ignored.
- Arithmetic:
  - add/sub are signed.
  - mul uses a 2*MAG_W-bit magnitude product with sign = XOR of the operand signs.
- If |R| > MAX_VAL: err=1, disp_mag=0, disp_neg=0, res_valid=1; state ERROR.
- ERROR: every event except clear is ignored.
- Zero result always has disp_neg=0.

Optional Feature:
- Macro: CALC_BCD_OUT_EN.
- Defined:
  - Adds output ports disp_bcd (4*MAX_DIGITS) and bcd_valid (1).
  - An iterative double-dabble converter starts on every disp_mag change and finishes after MAG_W cycles; bcd_valid=1 from then until the next change.
  - A disp_mag change mid-conversion restarts the conversion. Reset clears both ports.
- Undefined: no BCD ports and no converter logic; the display path converts externally.

Decomposition:
- calc_pkg: op codes (OP_ADD, OP_SUB, OP_MUL, OP_CLR), state enum (ENTER_A, OP_WAIT, ENTER_B, RESULT, ERROR), MAX_VAL default.
- One sub-module, calc_bin2bcd: sequential double-dabble converter, instantiated only under CALC_BCD_OUT_EN.

Test Plan:
- Keys 1,2,+,3,4,= → disp_mag 12 then 34, then 46 with disp_neg=0 and one res_valid pulse.
- Keys 5,-,9,= → disp_mag=4, disp_neg=1; then *,3,= → disp_mag=12, disp_neg=1.
- Keys 9,9,9,9,9 → fifth digit ignored, disp_mag=9999; then *,2,= → err=1, disp_mag=0; a following digit 7 is ignored; op 11 → err=0, disp 0.
- Keys 2,+,3,*,4,= → chained: disp_mag=5 after '*', then 20 at '='.
- Same-cycle press with is_eq=1 and is_num=1 (after 2,+,3) → treated as '=', disp_mag=5; press with no flag set → no change.
- Reset asserted during ENTER_B with B=7 → all outputs 0, then 1,= → disp_mag=1.
- With CALC_BCD_OUT_EN: result 46 → bcd_valid=0, then disp_bcd=16'h0046 and bcd_valid=1 after MAG_W cycles.
